// File: rtl/deserializador_param_if.sv
`default_nettype none
// ============================================================================
// Module      : deserializador_param_if
// Description : Serial-in / word-out bus between the serial front end and the
//               word consumer of the parametrised deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
interface deserializador_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                         data_in;
    logic                         write_in;
    logic                         ack_in;
    logic                         status_out;
    logic [WIDTH-1:0]             data_out;
    logic                         data_ready;
    logic [$clog2(DEPTH+1)-1:0]   fifo_level;
    logic                         overflow;

    modport master (
        output data_in, write_in, ack_in,
        input  status_out, data_out, data_ready, fifo_level, overflow
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output status_out, data_out, data_ready, fifo_level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/deserializador_param.sv
`default_nettype none
// ============================================================================
// Module      : deserializador_param
// Description : Assembles WIDTH serial bits into words and queues them in a
//               DEPTH-entry FIFO drained by an ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializador_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk_100KHz,
    input  wire logic             reset,
    deserializador_param_if.slave bus
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_status;

    logic [c_CNT_W-1:0]   r_bit_cnt;
    // Only WIDTH-1 bits need storing: the final bit arrives on the completing edge.
    logic [WIDTH-2:0]     r_shift;
    logic [WIDTH-1:0]     w_word;
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_LVL_W-1:0]   w_level_next;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;

    assign w_not_empty = (r_level != '0);
    assign w_accept    = bus.write_in && w_status;
    assign w_push      = w_accept && (r_bit_cnt == c_CNT_LAST);
    assign w_pop       = bus.ack_in && w_not_empty;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_word = {r_shift, bus.data_in};
        end else begin : g_lsb_first
            assign w_word = {bus.data_in, r_shift};
        end
    endgenerate

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_status     = 1'b1;
        case (r_state)
            ST_COLLECT: begin
                w_status = 1'b1;
                if (w_level_next == c_LVL_FULL) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                w_status = 1'b0;
                if (w_pop) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            r_state    <= ST_COLLECT;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            if (w_accept) begin
                if (w_push) begin
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    r_wr_ptr  <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_shift   <= MSB_FIRST ? w_word[WIDTH-2:0] : w_word[WIDTH-1:1];
                end
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (bus.write_in && !w_status) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the level is zero.
    always_ff @(posedge clk_100KHz) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign bus.status_out = w_status;
    assign bus.data_ready = w_not_empty;
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.data_out   = w_not_empty ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_deserializador_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializador_param
// Description : Directed self-checking bench; drives MSB-first and LSB-first
//               instances with the same serial stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializador_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_in = 1'b0;
    logic write_in = 1'b0;
    logic ack_in = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    deserializador_param_if #(.WIDTH(8), .DEPTH(4)) if_a ();
    deserializador_param_if #(.WIDTH(8), .DEPTH(4)) if_b ();

    assign if_a.data_in  = data_in;
    assign if_a.write_in = write_in;
    assign if_a.ack_in   = ack_in;
    assign if_b.data_in  = data_in;
    assign if_b.write_in = write_in;
    assign if_b.ack_in   = ack_in;

    deserializador_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk_100KHz (clk),
        .reset      (rst),
        .bus        (if_a)
    );

    deserializador_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk_100KHz (clk),
        .reset      (rst),
        .bus        (if_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bits go out w[7] first; ack_last raises ack_in on the completing edge.
    task automatic send_word(input logic [7:0] w, input logic ack_last);
        for (int i = 7; i >= 0; i--) begin
            data_in  = w[i];
            write_in = 1'b1;
            ack_in   = (i == 0) && ack_last;
            tick();
        end
        write_in = 1'b0;
        ack_in   = 1'b0;
        data_in  = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_status", 32'(if_a.status_out), 32'd1);
        chk("rst_ready",  32'(if_a.data_ready), 32'd0);
        chk("rst_data",   32'(if_a.data_out),   32'h00);
        chk("rst_level",  32'(if_a.fifo_level), 32'd0);
        chk("rst_ovf",    32'(if_a.overflow),   32'd0);

        // 1,0,1,0,1,1,0,1 -> AD MSB-first, B5 LSB-first
        send_word(8'hAD, 1'b0);
        chk("msb_ready", 32'(if_a.data_ready), 32'd1);
        chk("msb_data",  32'(if_a.data_out),   32'hAD);
        chk("msb_level", 32'(if_a.fifo_level), 32'd1);
        chk("lsb_data",  32'(if_b.data_out),   32'hB5);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk("pop_ready", 32'(if_a.data_ready), 32'd0);
        chk("pop_data",  32'(if_a.data_out),   32'h00);
        chk("pop_lsb_level", 32'(if_b.fifo_level), 32'd0);

        // Fill to DEPTH, then overflow
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        send_word(8'h03, 1'b0);
        chk("fill3_level",  32'(if_a.fifo_level), 32'd3);
        chk("fill3_status", 32'(if_a.status_out), 32'd1);
        send_word(8'h04, 1'b0);
        chk("full_level",  32'(if_a.fifo_level), 32'd4);
        chk("full_status", 32'(if_a.status_out), 32'd0);
        chk("full_head",   32'(if_a.data_out),   32'h01);
        chk("full_ovf0",   32'(if_a.overflow),   32'd0);
        data_in  = 1'b1;
        write_in = 1'b1;
        tick();
        write_in = 1'b0;
        chk("ovf_set",   32'(if_a.overflow),   32'd1);
        chk("ovf_level", 32'(if_a.fifo_level), 32'd4);
        tick();
        chk("ovf_sticky", 32'(if_a.overflow), 32'd1);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk("unfull_data",   32'(if_a.data_out),   32'h02);
        chk("unfull_status", 32'(if_a.status_out), 32'd1);
        chk("unfull_level",  32'(if_a.fifo_level), 32'd3);

        // Mid-word reset discards partial bits
        for (int i = 0; i < 3; i++) begin
            data_in  = 1'b1;
            write_in = 1'b1;
            tick();
        end
        write_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_level", 32'(if_a.fifo_level), 32'd0);
        send_word(8'hC3, 1'b0);
        chk("c3_data",     32'(if_a.data_out),   32'hC3);
        chk("c3_level",    32'(if_a.fifo_level), 32'd1);
        chk("c3_ovf",      32'(if_a.overflow),   32'd0);
        chk("c3_lsb_data", 32'(if_b.data_out),   32'hC3);

        // Simultaneous push and pop at level 3
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk("pre_sim_level", 32'(if_a.fifo_level), 32'd3);
        send_word(8'h5A, 1'b1);
        chk("sim_level", 32'(if_a.fifo_level), 32'd3);
        chk("sim_head",  32'(if_a.data_out),   32'h11);
        ack_in = 1'b1;
        tick();
        chk("drain1_head", 32'(if_a.data_out), 32'h22);
        tick();
        chk("drain2_head", 32'(if_a.data_out), 32'h5A);
        chk("lsb_drain2_head", 32'(if_b.data_out), 32'h5A);
        tick();
        chk("drain_empty_ready", 32'(if_a.data_ready), 32'd0);
        chk("drain_empty_data",  32'(if_a.data_out),   32'h00);
        tick();
        ack_in = 1'b0;
        chk("ack_empty_level", 32'(if_a.fifo_level), 32'd0);
        chk("ack_empty_status", 32'(if_a.status_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
